// File: rtl/bias_weight_bank.sv
// Bias-weight table for the neural branch predictor: signed saturating weights,
// 1-cycle prediction read, 2-stage training RMW, predicted-weight history.
// Optional same-edge read/write bypass: define BIAS_WT_FWD_EN.
module bias_weight_bank #(
  parameter int IDX_W      = 10,
  parameter int WT_W       = 4,
  parameter int HIST_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       pred_valid,
  input  logic [IDX_W-1:0]           pred_index,
  output logic [WT_W-1:0]            pred_weight,
  output logic                       pred_weight_valid,
  input  logic                       upd_valid,
  input  logic [IDX_W-1:0]           upd_index,
  input  logic                       upd_taken,
  input  logic                       hist_flush,
  output logic [HIST_DEPTH*WT_W-1:0] hist_weights,
  output logic                       dbg_state
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int HW    = HIST_DEPTH * WT_W;
  localparam logic [WT_W-1:0] WT_MAX = {1'b0, {(WT_W-1){1'b1}}};
  localparam logic [WT_W-1:0] WT_MIN = {1'b1, {(WT_W-1){1'b0}}};

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             u_valid_q, u_valid_d;
  logic [IDX_W-1:0] u_idx_q, u_idx_d;
  logic             u_taken_q, u_taken_d;
  logic [WT_W-1:0]  u_old_q, u_old_d;
  logic [WT_W-1:0]  pw_q, pw_d;
  logic             pwv_q, pwv_d;
  logic [HW-1:0]    hist_q, hist_d;

  logic [WT_W-1:0]  wt_mem [DEPTH];
  logic             run;
  logic [WT_W-1:0]  wr_data;
  logic [WT_W-1:0]  rd_data;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [WT_W-1:0]  mem_wdata;

  assign run = (state_q == ST_RUN);

  // Handshake: pred_valid/upd_valid are accepted at any edge where ready=1;
  // there is no backpressure, and requests seen while ready=0 are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == {IDX_W{1'b1}}) state_d = ST_RUN;
    end
  end

  // Second update stage: saturating +/-1 of the value captured by the first.
  always_comb begin
    wr_data = u_old_q;
    if (u_taken_q) begin
      if (u_old_q != WT_MAX) wr_data = u_old_q + WT_W'(1);
    end else begin
      if (u_old_q != WT_MIN) wr_data = u_old_q - WT_W'(1);
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = u_idx_q;
    mem_wdata = wr_data;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (u_valid_q) begin
      mem_we = 1'b1;
    end
  end

  // First stage takes the in-flight write result when it targets the same entry.
  always_comb begin
    u_valid_d = run & upd_valid;
    u_idx_d   = upd_index;
    u_taken_d = upd_taken;
    u_old_d   = wt_mem[upd_index];
    if (u_valid_q && (u_idx_q == upd_index)) u_old_d = wr_data;
  end

  always_comb begin
`ifdef BIAS_WT_FWD_EN
    rd_data = wt_mem[pred_index];
    if (u_valid_q && (u_idx_q == pred_index)) rd_data = wr_data;
`else
    rd_data = wt_mem[pred_index];
`endif
    pwv_d = run & pred_valid;
    pw_d  = pwv_d ? rd_data : pw_q;
  end

  always_comb begin
    hist_d = hist_q;
    if (hist_flush)  hist_d = '0;
    else if (pwv_q)  hist_d = {pw_q, hist_q[HW-1:WT_W]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      u_valid_q <= 1'b0;
      u_idx_q   <= '0;
      u_taken_q <= 1'b0;
      u_old_q   <= '0;
      pw_q      <= '0;
      pwv_q     <= 1'b0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      u_valid_q <= u_valid_d;
      u_idx_q   <= u_idx_d;
      u_taken_q <= u_taken_d;
      u_old_q   <= u_old_d;
      pw_q      <= pw_d;
      pwv_q     <= pwv_d;
      hist_q    <= hist_d;
    end
  end

  // Table contents are not reset; the init sweep clears them.
  always_ff @(posedge clk) begin
    if (mem_we) wt_mem[mem_waddr] <= mem_wdata;
  end

  assign ready             = run;
  assign pred_weight       = pw_q;
  assign pred_weight_valid = pwv_q;
  assign hist_weights      = hist_q;
  assign dbg_state         = state_q;

endmodule
